// File: rtl/mips_pkg.sv
// Shared definitions for the mips_core front end.
package mips_pkg;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;
endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bundle: imem request channel, redirect input and decode channel.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus4;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/mips_fetch_buffer.sv
// Small FIFO of {instr, pc} pairs between imem and decode. Head is
// presented directly; outputs read as zero while empty.
module mips_fetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [DATA_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  import mips_pkg::*;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] pc_d    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok, push_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign pop_ok = pop && !empty;
  // A full queue still accepts a push when the head leaves the same cycle.
  assign push_ok = push && (!full || pop_ok);

  assign head_instr = empty ? DATA_W'(INSTR_NOP) : instr_q[rd_ptr_q];
  assign head_pc    = empty ? '0 : pc_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, count and storage; flush wins over push/pop.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        instr_d[wr_ptr_q] = push_instr;
        pc_d[wr_ptr_q]    = push_pc;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the imem req/ack handshake
// and feeds decode from a small queue. Redirects flush everything and may
// leave one squashed fetch to drain.
module mips_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(mips_pkg::RESET_PC),
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] head_pc;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full, buf_empty;
  logic              push, pop, slot_free;

  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  // A redirect suppresses both the pop and any same-cycle fill.
  assign pop  = if_valid && if_ready && !redirect_valid;
  assign push = imem_ack && (state_q == REQ) && !redirect_valid
                && (!buf_full || pop);

  // Room left once this cycle's push and pop have both landed.
  assign slot_free = (int'(buf_count) + (push ? 1 : 0) - (pop ? 1 : 0))
                     < BUF_DEPTH;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign if_valid    = !buf_empty;
  assign if_pc       = head_pc;
  assign if_pc_plus4 = buf_empty ? '0 : head_pc + ADDR_W'(4);

  mips_fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (fetch_pc_q),
    .pop        (pop),
    .head_instr (if_instr),
    .head_pc    (head_pc),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // Next fetch state and fetch PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (redirect_valid) state_d = imem_ack ? REQ : DRAIN;
        else if (imem_ack)  state_d = slot_free ? REQ : WAIT;
      end
      WAIT:  if (redirect_valid || pop) state_d = REQ;
      DRAIN: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (push)           fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (redirect_valid) fetch_pc_d = redirect_tgt;
  end

  // FSM and PC registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: a memory model pushes expected
// {instr, pc} on every live ack, a monitor pops and compares on each
// decode handshake. A second instance covers PC wrap-around.
module tb_mips_fetch_unit;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] BEEF    = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mips_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC), .BUF_DEPTH(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (bus.imem_req),
    .imem_addr      (bus.imem_addr),
    .imem_ack       (bus.imem_ack),
    .imem_rdata     (bus.imem_rdata),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .if_valid       (bus.if_valid),
    .if_ready       (bus.if_ready),
    .if_instr       (bus.if_instr),
    .if_pc          (bus.if_pc),
    .if_pc_plus4    (bus.if_pc_plus4)
  );

  // Wrap-around instance: always ready, never redirected.
  logic        w_rst = 1'b0;
  logic        w_req, w_valid;
  logic        w_ack = 1'b0;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_p4;
  logic        w_redir = 1'b0;
  logic [31:0] w_redir_pc = 32'h0;
  logic        w_ready = 1'b1;

  mips_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(WRAP_PC), .BUF_DEPTH(2)
  ) dut_wrap (
    .clock          (clock),
    .reset          (w_rst),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ack       (w_ack),
    .imem_rdata     (w_rdata),
    .redirect_valid (w_redir),
    .redirect_pc    (w_redir_pc),
    .if_valid       (w_valid),
    .if_ready       (w_ready),
    .if_instr       (w_instr),
    .if_pc          (w_pc),
    .if_pc_plus4    (w_p4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endfunction

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // ---------------- reference model / memory ----------------
  ent_t        exp_q[$];
  bit          busy = 0, stale = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  int          lat = 0, lat_min = 0, lat_max = 0;
  bit          ack_nxt = 0, stray_ack = 0, seen_beef = 0;
  logic [31:0] rdata_nxt = '0;

  // Memory accepts one request at a time; any request in flight when a
  // redirect arrives is stale and answers with BEEF, which must never
  // reach decode. Live acks append the next sequential instruction.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      busy    = 0;
      stale   = 0;
      exp_pc  = RST_PC;
      ack_nxt = 0;
    end else begin
      if (bus.imem_ack && busy) begin
        if (!bus.redirect_valid && !stale) begin
          exp_q.push_back('{instr: mem_word(mem_addr), pc: mem_addr});
          exp_pc = exp_pc + 32'd4;
        end
        busy  = 0;
        stale = 0;
      end else if (busy) begin
        if (stale) chk("drain_req_low", {31'b0, bus.imem_req}, 32'd0);
        else begin
          chk("req_held", {31'b0, bus.imem_req}, 32'd1);
          chk("addr_stable", bus.imem_addr, mem_addr);
        end
      end else if (bus.imem_req && !bus.imem_ack) begin
        chk("fetch_addr", bus.imem_addr, exp_pc);
        busy     = 1;
        mem_addr = bus.imem_addr;
        lat      = $urandom_range(lat_max, lat_min);
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        exp_pc = bus.redirect_pc & ~32'd3;
        if (busy) stale = 1;
      end
      ack_nxt = 0;
      if (busy) begin
        if (lat == 0) begin
          ack_nxt   = 1;
          rdata_nxt = stale ? BEEF : mem_word(mem_addr);
        end else lat--;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    bus.imem_ack   = ack_nxt | stray_ack;
    bus.imem_rdata = ack_nxt ? rdata_nxt : 32'h0BAD_0BAD;
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin : mon
    ent_t e;
    if (reset) begin
      chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("rst_addr",  bus.imem_addr, RST_PC);
      chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("rst_instr", bus.if_instr, 32'd0);
      chk("rst_pc",    bus.if_pc, 32'd0);
      chk("rst_pc4",   bus.if_pc_plus4, 32'd0);
    end else if (!bus.if_valid) begin
      chk("empty_instr", bus.if_instr, 32'd0);
      chk("empty_pc",    bus.if_pc, 32'd0);
      chk("empty_pc4",   bus.if_pc_plus4, 32'd0);
    end else begin
      if (bus.if_instr == BEEF) seen_beef = 1;
      if (bus.if_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h expected no entry", bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc",    bus.if_pc, e.pc);
          chk("if_instr", bus.if_instr, e.instr);
          chk("if_pc4",   bus.if_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  // ---------------- wrap instance memory + recorder ----------------
  logic [31:0] w_pcs[$], w_ins[$], w_p4s[$], w_addrs[$];

  always @(posedge clock) begin
    #2;
    w_ack   = w_req && !w_ack;
    w_rdata = mem_word(w_addr);
  end

  always @(negedge clock) begin
    if (!w_rst) begin
      if (w_valid && w_pcs.size() < 8) begin
        w_pcs.push_back(w_pc);
        w_ins.push_back(w_instr);
        w_p4s.push_back(w_p4);
      end
      if (w_ack && w_req && w_addrs.size() < 8) w_addrs.push_back(w_addr);
    end
  end

  initial begin
    #1 w_rst = 1'b1;
    repeat (3) @(posedge clock);
    #1 w_rst = 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #1 reset = 1'b1;

    // Reset release with quick memory and decode always ready.
    lat_min = 0; lat_max = 0;
    do_reset();
    @(negedge clock); #1;
    chk("idle_no_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clock); #1;
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, RST_PC);
    cycles(12);

    // Decode stalled: queue fills to two entries and fetch parks.
    bus.if_ready = 1'b0;
    do_reset();
    repeat (6) @(posedge clock);
    @(negedge clock); #1;
    chk("wait_req_low", {31'b0, bus.imem_req}, 32'd0);
    chk("wait_qdepth", exp_q.size(), 32'd2);
    chk("wait_hold_pc", bus.if_pc, 32'h0);
    @(posedge clock); #1;
    bus.if_ready = 1'b1;
    begin
      int k = 0;
      while (!bus.imem_req && k < 20) begin @(negedge clock); #1; k++; end
      if (k >= 20) timeout("resume_wait");
      else chk("resume_addr", bus.imem_addr, 32'h8);
    end
    cycles(6);

    // Redirect from a full, parked queue.
    bus.if_ready = 1'b0;
    begin
      int k = 0;
      while (!(!bus.imem_req && exp_q.size() == 2) && k < 20) begin
        @(negedge clock); #1; k++;
      end
      if (k >= 20) timeout("full_wait");
    end
    @(posedge clock); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(posedge clock); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clock); #1;
    chk("redir_valid_low", {31'b0, bus.if_valid}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h0000_0100);
    bus.if_ready = 1'b1;
    begin
      int k = 0;
      while (!bus.if_valid && k < 20) begin @(negedge clock); #1; k++; end
      if (k >= 20) timeout("redir_deliver");
      else chk("redir_first_pc", bus.if_pc, 32'h0000_0100);
    end
    cycles(4);

    // Redirect while the fetch of 0x8 is in flight; its ack comes later.
    lat_min = 3; lat_max = 3;
    seen_beef = 0;
    do_reset();
    begin
      int k = 0;
      while (!(busy && !stale && mem_addr == 32'h8) && k < 60) begin
        @(negedge clock); #1; k++;
      end
      if (k >= 60) timeout("drain_setup");
    end
    @(posedge clock); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    lat_min = 0; lat_max = 0;
    @(posedge clock); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clock); #1;
    chk("drain_req_off", {31'b0, bus.imem_req}, 32'd0);
    begin
      int k = 0;
      while (!bus.if_valid && k < 30) begin @(negedge clock); #1; k++; end
      if (k >= 30) timeout("drain_deliver");
      else chk("drain_first_pc", bus.if_pc, 32'h0000_0200);
    end
    chk("drain_discard", {31'b0, seen_beef}, 32'd0);
    cycles(4);

    // Reset in the middle of a request, stray ack right after release.
    lat_min = 2; lat_max = 2;
    begin
      int k = 0;
      while (!(bus.imem_req && busy) && k < 20) begin @(negedge clock); #1; k++; end
      if (k >= 20) timeout("midreq_setup");
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    chk("midrst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, bus.if_valid}, 32'd0);
    @(posedge clock); #1;
    reset     = 1'b0;
    stray_ack = 1'b1;
    @(posedge clock); #1;
    stray_ack = 1'b0;
    @(negedge clock); #1;
    chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
    chk("post_rst_addr", bus.imem_addr, RST_PC);
    chk("post_rst_valid", {31'b0, bus.if_valid}, 32'd0);
    lat_min = 0; lat_max = 0;
    cycles(8);

    // Random traffic: ready, latency and redirects all randomized.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 99) < 4);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                           (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
    end
    @(posedge clock); #1;
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    lat_min = 0; lat_max = 0;
    cycles(20);

    // Wrap-around instance results.
    if (w_pcs.size() < 3 || w_addrs.size() < 3) timeout("wrap_collect");
    else begin
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", w_addrs[2], 32'h0000_0000);
      chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", w_pcs[2], 32'h0000_0000);
      chk("wrap_pc4_1", w_p4s[1], 32'h0000_0000);
      chk("wrap_instr1", w_ins[1], mem_word(32'hFFFF_FFFC));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
